// File: rtl/interconnect_write_addr_channel_pkg.sv
// Shared definitions for the two-master write-address interconnect:
// arbiter state encoding, slave-select width and beat-counter width.
package interconnect_write_addr_channel_pkg;

  typedef enum logic [3:0] {
    M0_PRI_IDLE   = 4'b0001,
    M1_PRI_IDLE   = 4'b0010,
    M0_WAIT_READY = 4'b0100,
    M1_WAIT_READY = 4'b1000
  } arb_state_e;

  localparam int SEL_W  = 2;
  localparam int BEAT_W = 8;

  // Top address bits pick one of four slaves.
  function automatic logic [3:0] slave_onehot(input logic [SEL_W-1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/interconnect_write_addr_channel_if.sv
// AW-channel bundle between two masters, four slaves and the write data channel.
// Modport slave is the interconnect view; modport master is the surrounding system.
interface interconnect_write_addr_channel_if #(
  parameter int AWIDTH  = 32,
  parameter int IDWIDTH = 4
);

  logic               AWVALID_M0;
  logic [AWIDTH-1:0]  AWADDR_M0;
  logic [IDWIDTH-1:0] AWID_M0;
  logic [7:0]         AWLEN_M0;
  logic [2:0]         AWSIZE_M0;
  logic [1:0]         AWBURST_M0;
  logic               AWREADY_M0;

  logic               AWVALID_M1;
  logic [AWIDTH-1:0]  AWADDR_M1;
  logic [IDWIDTH-1:0] AWID_M1;
  logic [7:0]         AWLEN_M1;
  logic [2:0]         AWSIZE_M1;
  logic [1:0]         AWBURST_M1;
  logic               AWREADY_M1;

  logic AWVALID_S0, AWVALID_S1, AWVALID_S2, AWVALID_S3;
  logic AWREADY_S0, AWREADY_S1, AWREADY_S2, AWREADY_S3;
  logic [AWIDTH-1:0]  AWADDR_S;
  logic [IDWIDTH:0]   AWID_S;
  logic [7:0]         AWLEN_S;
  logic [2:0]         AWSIZE_S;
  logic [1:0]         AWBURST_S;

  logic [1:0]         wrDataChanGrant;
  logic [AWIDTH-1:0]  wrDataChanAddr;
  logic               wrAddrErr;

  modport slave (
    input  AWVALID_M0, AWADDR_M0, AWID_M0, AWLEN_M0, AWSIZE_M0, AWBURST_M0,
    input  AWVALID_M1, AWADDR_M1, AWID_M1, AWLEN_M1, AWSIZE_M1, AWBURST_M1,
    output AWREADY_M0, AWREADY_M1,
    output AWVALID_S0, AWVALID_S1, AWVALID_S2, AWVALID_S3,
    input  AWREADY_S0, AWREADY_S1, AWREADY_S2, AWREADY_S3,
    output AWADDR_S, AWID_S, AWLEN_S, AWSIZE_S, AWBURST_S,
    input  wrDataChanGrant,
    output wrDataChanAddr, wrAddrErr
  );

  modport master (
    output AWVALID_M0, AWADDR_M0, AWID_M0, AWLEN_M0, AWSIZE_M0, AWBURST_M0,
    output AWVALID_M1, AWADDR_M1, AWID_M1, AWLEN_M1, AWSIZE_M1, AWBURST_M1,
    input  AWREADY_M0, AWREADY_M1,
    input  AWVALID_S0, AWVALID_S1, AWVALID_S2, AWVALID_S3,
    output AWREADY_S0, AWREADY_S1, AWREADY_S2, AWREADY_S3,
    input  AWADDR_S, AWID_S, AWLEN_S, AWSIZE_S, AWBURST_S,
    output wrDataChanGrant,
    input  wrDataChanAddr, wrAddrErr
  );

endinterface

// File: rtl/interconnect_addr_hold_fifo.sv
// Per-master queue of accepted burst {address, length} awaiting their data beats.
// DEPTH must be a power of two, at least 2.
module interconnect_addr_hold_fifo #(
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [AWIDTH-1:0] push_addr,
  input  logic [LEN_W-1:0]  push_len,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [AWIDTH-1:0] head_addr,
  output logic [LEN_W-1:0]  head_len
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [AWIDTH-1:0] addr_mem [DEPTH];
  logic [LEN_W-1:0]  len_mem  [DEPTH];
  logic              do_push, do_pop;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head_addr = addr_mem[rd_ptr[PTR_W-1:0]];
  assign head_len  = len_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      addr_mem[wr_ptr[PTR_W-1:0]] <= push_addr;
      len_mem[wr_ptr[PTR_W-1:0]]  <= push_len;
    end
  end

endmodule

// File: rtl/interconnect_write_addr_channel.sv
// Two-master, four-slave write-address interconnect with round-robin arbitration
// and per-master address hold queues feeding the write data channel.
module interconnect_write_addr_channel
  import interconnect_write_addr_channel_pkg::*;
#(
  parameter int AWIDTH  = 32,
  parameter int IDWIDTH = 4,
  parameter int HDEPTH  = 4
) (
  input logic clock,
  input logic reset,
  interconnect_write_addr_channel_if.slave aw
);

  arb_state_e         state;
  logic [1:0]         awready_m;
  logic [3:0]         awvalid_s;
  logic [AWIDTH-1:0]  bus_addr;
  logic [IDWIDTH:0]   bus_id;
  logic [7:0]         bus_len;
  logic [2:0]         bus_size;
  logic [1:0]         bus_burst;

  logic [3:0]         awready_s;
  logic               slv_hs;
  logic [1:0]         full, empty, push, gnt, pop;
  logic               req0, req1;
  logic               grant_valid, grant_m;

  logic [AWIDTH-1:0]  m_addr;
  logic [IDWIDTH-1:0] m_id;
  logic [7:0]         m_len;
  logic [2:0]         m_size;
  logic [1:0]         m_burst;

  logic [AWIDTH-1:0]  head_addr [2];
  logic [BEAT_W-1:0]  head_len  [2];
  logic [BEAT_W-1:0]  beat_cnt  [2];
  logic               addr_err;
  logic [AWIDTH-1:0]  data_addr;

  assign awready_s = {aw.AWREADY_S3, aw.AWREADY_S2, aw.AWREADY_S1, aw.AWREADY_S0};
  assign slv_hs    = |(awvalid_s & awready_s);

  // A master still seeing its accept pulse is retiring the request just taken.
  assign req0 = aw.AWVALID_M0 & ~awready_m[0] & ~full[0];
  assign req1 = aw.AWVALID_M1 & ~awready_m[1] & ~full[1];

  always_comb begin
    grant_valid = 1'b0;
    grant_m     = 1'b0;
    unique case (state)
      M0_PRI_IDLE: begin
        if (req0)      begin grant_valid = 1'b1; grant_m = 1'b0; end
        else if (req1) begin grant_valid = 1'b1; grant_m = 1'b1; end
      end
      M1_PRI_IDLE: begin
        if (req1)      begin grant_valid = 1'b1; grant_m = 1'b1; end
        else if (req0) begin grant_valid = 1'b1; grant_m = 1'b0; end
      end
      default: ;
    endcase
  end

  assign m_addr  = grant_m ? aw.AWADDR_M1  : aw.AWADDR_M0;
  assign m_id    = grant_m ? aw.AWID_M1    : aw.AWID_M0;
  assign m_len   = grant_m ? aw.AWLEN_M1   : aw.AWLEN_M0;
  assign m_size  = grant_m ? aw.AWSIZE_M1  : aw.AWSIZE_M0;
  assign m_burst = grant_m ? aw.AWBURST_M1 : aw.AWBURST_M0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= M0_PRI_IDLE;
      awready_m <= 2'b00;
      awvalid_s <= 4'b0000;
      bus_addr  <= '0;
      bus_id    <= '0;
      bus_len   <= '0;
      bus_size  <= '0;
      bus_burst <= '0;
    end else begin
      awready_m <= 2'b00;
      unique case (state)
        M0_PRI_IDLE, M1_PRI_IDLE: begin
          if (grant_valid) begin
            bus_addr  <= m_addr;
            bus_id    <= {grant_m, m_id};
            bus_len   <= m_len;
            bus_size  <= m_size;
            bus_burst <= m_burst;
            awvalid_s <= slave_onehot(m_addr[AWIDTH-1 -: SEL_W]);
            state     <= grant_m ? M1_WAIT_READY : M0_WAIT_READY;
          end
        end
        M0_WAIT_READY: begin
          if (slv_hs) begin
            awvalid_s    <= 4'b0000;
            awready_m[0] <= 1'b1;
            state        <= M1_PRI_IDLE;
          end
        end
        M1_WAIT_READY: begin
          if (slv_hs) begin
            awvalid_s    <= 4'b0000;
            awready_m[1] <= 1'b1;
            state        <= M0_PRI_IDLE;
          end
        end
        default: state <= M0_PRI_IDLE;
      endcase
    end
  end

  // The accepted burst is still on the shared bus at the handshake edge.
  assign push[0] = (state == M0_WAIT_READY) & slv_hs;
  assign push[1] = (state == M1_WAIT_READY) & slv_hs;

  interconnect_addr_hold_fifo #(.AWIDTH(AWIDTH), .DEPTH(HDEPTH), .LEN_W(BEAT_W)) u_hold_m0 (
    .clock     (clock),
    .reset     (reset),
    .push      (push[0]),
    .push_addr (bus_addr),
    .push_len  (bus_len),
    .pop       (pop[0]),
    .full      (full[0]),
    .empty     (empty[0]),
    .head_addr (head_addr[0]),
    .head_len  (head_len[0])
  );

  interconnect_addr_hold_fifo #(.AWIDTH(AWIDTH), .DEPTH(HDEPTH), .LEN_W(BEAT_W)) u_hold_m1 (
    .clock     (clock),
    .reset     (reset),
    .push      (push[1]),
    .push_addr (bus_addr),
    .push_len  (bus_len),
    .pop       (pop[1]),
    .full      (full[1]),
    .empty     (empty[1]),
    .head_addr (head_addr[1]),
    .head_len  (head_len[1])
  );

  // Grant 2'b11 is not one-hot and is ignored entirely.
  assign gnt[0] = (aw.wrDataChanGrant == 2'b01);
  assign gnt[1] = (aw.wrDataChanGrant == 2'b10);

  always_comb begin
    pop = 2'b00;
    for (int m = 0; m < 2; m++)
      pop[m] = gnt[m] & ~empty[m] & (beat_cnt[m] == head_len[m]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_cnt[0] <= '0;
      beat_cnt[1] <= '0;
      addr_err    <= 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (gnt[m] & ~empty[m])
          beat_cnt[m] <= pop[m] ? '0 : beat_cnt[m] + 1'b1;
      end
      if (|(gnt & empty)) addr_err <= 1'b1;
    end
  end

  always_comb begin
    data_addr = '0;
    if (gnt[0] & ~empty[0])      data_addr = head_addr[0];
    else if (gnt[1] & ~empty[1]) data_addr = head_addr[1];
  end

  assign aw.AWREADY_M0     = awready_m[0];
  assign aw.AWREADY_M1     = awready_m[1];
  assign aw.AWVALID_S0     = awvalid_s[0];
  assign aw.AWVALID_S1     = awvalid_s[1];
  assign aw.AWVALID_S2     = awvalid_s[2];
  assign aw.AWVALID_S3     = awvalid_s[3];
  assign aw.AWADDR_S       = bus_addr;
  assign aw.AWID_S         = bus_id;
  assign aw.AWLEN_S        = bus_len;
  assign aw.AWSIZE_S       = bus_size;
  assign aw.AWBURST_S      = bus_burst;
  assign aw.wrDataChanAddr = data_addr;
  assign aw.wrAddrErr      = addr_err;

endmodule

// File: tb/tb_interconnect_write_addr_channel.sv
// Directed bench for the write-address interconnect: latency, round-robin order,
// hold-queue draining, full-queue stall, empty-grant error and async reset.
module tb_interconnect_write_addr_channel;
  import interconnect_write_addr_channel_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc0;
  logic [31:0] exp_q0 [3] = '{32'h8000_0100, 32'h0000_0300, 32'h4000_0400};

  interconnect_write_addr_channel_if #(.AWIDTH(32), .IDWIDTH(4)) bus ();

  interconnect_write_addr_channel #(.AWIDTH(32), .IDWIDTH(4), .HDEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .aw    (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] s_vld();
    return {bus.AWVALID_S3, bus.AWVALID_S2, bus.AWVALID_S1, bus.AWVALID_S0};
  endfunction

  task automatic set_ready(input logic [3:0] r);
    {bus.AWREADY_S3, bus.AWREADY_S2, bus.AWREADY_S1, bus.AWREADY_S0} = r;
  endtask

  task automatic m0(input logic v, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    bus.AWVALID_M0 = v; bus.AWADDR_M0 = a; bus.AWID_M0 = id; bus.AWLEN_M0 = len;
    bus.AWSIZE_M0 = 3'd2; bus.AWBURST_M0 = 2'd1;
  endtask

  task automatic m1(input logic v, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    bus.AWVALID_M1 = v; bus.AWADDR_M1 = a; bus.AWID_M1 = id; bus.AWLEN_M1 = len;
    bus.AWSIZE_M1 = 3'd3; bus.AWBURST_M1 = 2'd1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    m0(1'b0, 32'h0, 4'h0, 8'h0);
    m1(1'b0, 32'h0, 4'h0, 8'h0);
    set_ready(4'b0000);
    bus.wrDataChanGrant = 2'b00;

    // Reset state
    repeat (2) step();
    chk("rst_awvalid_s", s_vld(), 4'b0000);
    chk("rst_awready_m", {bus.AWREADY_M1, bus.AWREADY_M0}, 2'b00);
    chk("rst_bus", {bus.AWADDR_S, bus.AWID_S, bus.AWLEN_S}, '0);
    chk("rst_err", bus.wrAddrErr, 1'b0);
    chk("rst_fsm", dut.state, M0_PRI_IDLE);
    reset = 1'b0;
    step();
    chk("post_rst_quiet", {s_vld(), bus.AWREADY_M1, bus.AWREADY_M0}, 6'b0);

    // Minimum latency, M0 to slave 1
    m0(1'b1, 32'h4000_0010, 4'h5, 8'd3);
    set_ready(4'b0010);
    step();
    chk("lat_awvalid_s1", s_vld(), 4'b0010);
    chk("lat_addr", bus.AWADDR_S, 32'h4000_0010);
    chk("lat_id", bus.AWID_S, 5'h05);
    chk("lat_len", bus.AWLEN_S, 8'd3);
    chk("lat_no_early_ready", bus.AWREADY_M0, 1'b0);
    step();
    chk("lat_awready_m0", bus.AWREADY_M0, 1'b1);
    chk("lat_awvalid_clear", s_vld(), 4'b0000);
    m0(1'b0, 32'h0, 4'h0, 8'h0);
    step();
    chk("lat_ready_pulse_one", bus.AWREADY_M0, 1'b0);

    // Round robin from reset
    rst_pulse();
    set_ready(4'b1111);
    m0(1'b1, 32'h8000_0100, 4'h1, 8'd0);
    m1(1'b1, 32'hC000_0200, 4'h2, 8'd3);
    step();
    chk("rr1_s2", s_vld(), 4'b0100);
    chk("rr1_addr", bus.AWADDR_S, 32'h8000_0100);
    chk("rr1_id", bus.AWID_S, 5'h01);
    step();
    chk("rr1_ready", {bus.AWREADY_M1, bus.AWREADY_M0}, 2'b01);
    m0(1'b1, 32'h0000_0300, 4'h1, 8'd0);
    step();
    chk("rr2_s3", s_vld(), 4'b1000);
    chk("rr2_addr", bus.AWADDR_S, 32'hC000_0200);
    chk("rr2_id", bus.AWID_S, 5'h12);
    step();
    chk("rr2_ready", {bus.AWREADY_M1, bus.AWREADY_M0}, 2'b10);
    m1(1'b0, 32'h0, 4'h0, 8'h0);
    step();
    chk("rr3_s0", s_vld(), 4'b0001);
    chk("rr3_addr", bus.AWADDR_S, 32'h0000_0300);
    step();
    chk("rr3_ready", bus.AWREADY_M0, 1'b1);
    m0(1'b0, 32'h0, 4'h0, 8'h0);
    step();
    m0(1'b1, 32'h4000_0400, 4'h1, 8'd0);
    m1(1'b1, 32'h4000_0500, 4'h2, 8'd3);
    step();
    chk("rr4_m1_first_addr", bus.AWADDR_S, 32'h4000_0500);
    chk("rr4_m1_first_id", bus.AWID_S, 5'h12);
    step();
    chk("rr4_ready", {bus.AWREADY_M1, bus.AWREADY_M0}, 2'b10);
    m1(1'b0, 32'h0, 4'h0, 8'h0);
    step();
    chk("rr5_addr", bus.AWADDR_S, 32'h4000_0400);
    chk("rr5_id", bus.AWID_S, 5'h01);
    step();
    chk("rr5_ready", bus.AWREADY_M0, 1'b1);
    m0(1'b0, 32'h0, 4'h0, 8'h0);
    step();

    // Drain queues: non-one-hot grant, AWLEN=0 bursts, AWLEN=3 bursts
    bus.wrDataChanGrant = 2'b11;
    #1;
    chk("grant11_addr", bus.wrDataChanAddr, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      bus.wrDataChanGrant = 2'b01;
      #1;
      chk("q0_beat_addr", bus.wrDataChanAddr, exp_q0[i]);
      step();
    end
    bus.wrDataChanGrant = 2'b00;
    chk("q0_empty", dut.u_hold_m0.empty, 1'b1);
    for (int i = 0; i < 8; i++) begin
      bus.wrDataChanGrant = 2'b10;
      #1;
      chk("q1_beat_addr", bus.wrDataChanAddr, (i < 4) ? 32'hC000_0200 : 32'h4000_0500);
      step();
    end
    bus.wrDataChanGrant = 2'b00;
    chk("q1_empty", dut.u_hold_m1.empty, 1'b1);
    chk("drain_no_err", bus.wrAddrErr, 1'b0);

    // Full M0 queue stalls M0 only
    rst_pulse();
    set_ready(4'b1111);
    m0(1'b1, 32'h0000_0040, 4'h3, 8'd0);
    acc0 = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.AWREADY_M0) acc0++;
    end
    chk("full_m0_accepts", acc0, 4);
    chk("full_m0_flag", dut.u_hold_m0.full, 1'b1);
    chk("full_m0_stalled", s_vld(), 4'b0000);
    m1(1'b1, 32'h4000_0080, 4'h6, 8'd0);
    step();
    chk("full_m1_s1", s_vld(), 4'b0010);
    chk("full_m1_id", bus.AWID_S, 5'h16);
    step();
    chk("full_m1_ready", bus.AWREADY_M1, 1'b1);
    m0(1'b0, 32'h0, 4'h0, 8'h0);
    m1(1'b0, 32'h0, 4'h0, 8'h0);

    // Grant to empty queue
    rst_pulse();
    bus.wrDataChanGrant = 2'b01;
    #1;
    chk("err_before", bus.wrAddrErr, 1'b0);
    chk("err_addr_zero", bus.wrDataChanAddr, 32'h0);
    step();
    chk("err_set", bus.wrAddrErr, 1'b1);
    bus.wrDataChanGrant = 2'b00;
    repeat (3) step();
    chk("err_sticky", bus.wrAddrErr, 1'b1);
    chk("err_q0_untouched", {dut.u_hold_m0.empty, dut.u_hold_m1.empty}, 2'b11);

    // Asynchronous reset while slave 2 is held waiting
    rst_pulse();
    set_ready(4'b0010);
    m0(1'b1, 32'h4000_0000, 4'h0, 8'd0);
    step();
    step();
    chk("ar_first_ready", bus.AWREADY_M0, 1'b1);
    m0(1'b1, 32'h8000_0000, 4'h0, 8'd0);
    step();
    step();
    chk("ar_s2_valid", s_vld(), 4'b0100);
    step();
    chk("ar_s2_held", s_vld(), 4'b0100);
    chk("ar_q0_nonempty", dut.u_hold_m0.empty, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_outputs", {s_vld(), bus.AWREADY_M1, bus.AWREADY_M0, bus.wrAddrErr}, 7'b0);
    chk("ar_bus", bus.AWADDR_S, 32'h0);
    chk("ar_fsm", dut.state, M0_PRI_IDLE);
    chk("ar_queues", {dut.u_hold_m0.empty, dut.u_hold_m1.empty}, 2'b11);
    m0(1'b0, 32'h0, 4'h0, 8'h0);
    step();
    reset = 1'b0;
    step();
    chk("ar_release_quiet", {s_vld(), bus.AWREADY_M1, bus.AWREADY_M0}, 6'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interconnect_write_addr_channel.md
INTERCONNECT_WRITE_ADDR_CHANNEL -- requirements
Module: interconnect_write_addr_channel

Interface
REQ-001 Parameters SHALL be: AWIDTH, default 32, address width; IDWIDTH, default 4, master ID width; HDEPTH, default 4, per-master address-hold queue depth (power of 2).
REQ-002 clock  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 AWVALID_Mm, AWADDR_Mm[AWIDTH], AWID_Mm[IDWIDTH], AWLEN_Mm[8], AWSIZE_Mm[3], AWBURST_Mm[2]  in  master m (m=0,1) write-address request.
REQ-005 AWREADY_Mm  out  1  registered one-cycle accept pulse to master m.
REQ-006 AWVALID_Sn  out  1  registered, per slave n (n=0..3); AWADDR_Sn, AWLEN_Sn, AWSIZE_Sn, AWBURST_Sn out, shared registered bus; AWID_Sn out [IDWIDTH+1] = {master index, AWID}.
REQ-007 AWREADY_Sn  in  1  slave n accept.
REQ-008 wrDataChanGrant  in  2  one-hot beat grant from the write data channel; 2'b00 = none.
REQ-009 wrDataChanAddr  out  AWIDTH  held burst address of the granted master, combinational from wrDataChanGrant.
REQ-010 wrAddrErr  out  1  sticky: grant received for master with empty hold queue.

Function
REQ-011 Arbiter SHALL be a 4-state round-robin FSM: M0_PRI_IDLE, M1_PRI_IDLE, M0_WAIT_READY, M1_WAIT_READY; reset state M0_PRI_IDLE.
REQ-012 In Mx_PRI_IDLE, master x SHALL be granted first if AWVALID_Mx & !AWREADY_Mx & hold queue x not full; otherwise the other master under the same condition; otherwise stay.
REQ-013 On grant (cycle 0), master AW fields SHALL be registered onto the shared slave bus and AWVALID_Sn set for n = AWADDR[AWIDTH-1:AWIDTH-2]; FSM moves to Mx_WAIT_READY.
REQ-014 AWVALID_Sn SHALL stay high, bus stable, until AWVALID_Sn & AWREADY_Sn; it SHALL then clear next cycle.
REQ-015 On slave handshake, AWREADY_Mx SHALL pulse high exactly the following cycle, FSM SHALL go to the other master's PRI_IDLE, and {AWADDR, AWLEN} SHALL push to hold queue x.
REQ-016 Minimum latency: AWVALID_Mx cycle 0 -> AWVALID_Sn cycle 1 -> AWREADY_Mx cycle 2 when AWREADY_Sn=1 in cycle 1.
REQ-017 Each cycle with wrDataChanGrant[x]=1 SHALL count one data beat of queue x head; beat counter x loads from head AWLEN; grant while counter == AWLEN SHALL pop head next edge.
REQ-018 wrDataChanAddr SHALL equal queue head address of the granted master in the same cycle; 0 when grant is 2'b00, 2'b11, or queue empty.
REQ-019 Grant to empty queue SHALL set wrAddrErr and leave queue/counter unchanged.
REQ-020 Simultaneous push and pop on the same queue SHALL both take effect; occupancy unchanged.
REQ-021 Full queue SHALL block arbitration of that master only; other master unaffected.
REQ-022 AWLEN=0 bursts SHALL pop on their first granted beat.

Reset
REQ-023 Reset SHALL clear: AWVALID_Sn, AWREADY_Mm, shared bus fields, queue pointers, beat counters, wrAddrErr to 0; FSM to M0_PRI_IDLE.
REQ-024 Reset mid-burst SHALL discard all held addresses; no output pulse SHALL occur in the first cycle after release.

Structure
REQ-025 Shared package SHALL hold FSM state encodings (one-hot, 4 bits), slave-select width (2), and the beat-counter width (8).
REQ-026 Hold queue SHALL be sub-module interconnect_addr_hold_fifo (push, pop, full, empty, head), instantiated per master.

Verification
REQ-027 M0 AWADDR=0x4000_0010, AWLEN=3, AWREADY_S1 held 1 -> AWVALID_S1 cycle 1, AWREADY_M0 cycle 2, AWID_S1={0,ID}.
REQ-028 M0 and M1 valid together from reset -> M0 served first, then M1; repeat -> M1 served first.
REQ-029 M1 burst AWLEN=3 held, 4 grants 2'b10 -> wrDataChanAddr = M1 addr each grant, queue empty after 4th.
REQ-030 Fill M0 queue with 4 bursts, no grants -> 5th M0 request stalls while M1 requests still accepted.
REQ-031 Grant 2'b01 with empty queue -> wrAddrErr=1 next cycle, stays 1 until reset.
REQ-032 Assert reset while AWVALID_S2=1 -> all outputs 0 asynchronously, FSM M0_PRI_IDLE, queues empty.
